// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: 1-to-4 valid/ready stream demux with per-channel output registers and beat counters
module demux_1_4_stream (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        up_valid,
    output logic        up_ready,
    input  logic [3:0]  up_data,
    input  logic [1:0]  up_sel,
    output logic [3:0]  down_valid,
    input  logic [3:0]  down_ready,
    output logic [15:0] down_data,
    input  logic        cnt_clear,
    output logic [31:0] cnt
);
    logic       xfer;
    logic [3:0] load;
    logic [3:0] drain;
    // Accept a beat when its channel is empty or emptying this cycle; decode the loaded channel
    always_comb begin
        up_ready = rst_n && (!down_valid[up_sel] || down_ready[up_sel]);
        xfer     = up_valid && up_ready;
        load     = xfer ? (4'b0001 << up_sel) : 4'b0000;
        drain    = down_valid & down_ready;
    end
    // Channel registers (load overrides drain) and delivered-beat counters (clear overrides count)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_valid <= '0;
            down_data  <= '0;
            cnt        <= '0;
        end else begin
            down_valid <= (down_valid & ~drain) | load;
            for (int c = 0; c < 4; c++) begin
                if (load[c])
                    down_data[4*c +: 4] <= up_data;
                if (cnt_clear)
                    cnt[8*c +: 8] <= 8'd0;
                else if (drain[c])
                    cnt[8*c +: 8] <= cnt[8*c +: 8] + 8'd1;
            end
        end
    end
endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Stream demultiplexer, the inverse of the 4:1 mux. It routes a 4-bit valid/ready input stream to one of four output channels, chosen per beat by a 2-bit select. Each channel has a one-entry output register, so the selected channel drains independently of the other three. Per-channel 8-bit delivered-beat counters support monitoring and self-checking benches.

## Interface
- No parameters. Data width is fixed at 4, channel count at 4, counter width at 8.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- up_valid  input  1  input beat present
- up_ready  output  1  block accepts input beat this cycle
- up_data  input  4  input beat payload
- up_sel  input  2  destination channel for the beat (0..3); sampled with up_data
- down_valid  output  4  bit i: channel i holds a beat
- down_ready  input  4  bit i: channel i consumer accepts
- down_data  output  16  channel i payload on bits [4i+3:4i]
- cnt_clear  input  1  synchronous clear of all counters
- cnt  output  32  channel i delivered-beat count on bits [8i+7:8i]

## Operation
- Input handshake: a beat transfers when up_valid && up_ready on a rising edge.
- up_ready = rst_n && (!down_valid[up_sel] || down_ready[up_sel]). It is combinational from up_sel, down_valid and down_ready, and has no dependency on up_valid.
  - A busy, non-draining channel blocks only beats addressed to it.
  - A beat to a free channel is accepted in the same cycle.
- Channel i register, per edge:
  - load (transfer && up_sel==i): down_data[i] <= up_data, down_valid[i] <= 1.
  - else drain (down_valid[i] && down_ready[i]): down_valid[i] <= 0, down_data[i] holds its last value.
  - else: hold.
  - Load and drain in the same cycle: the new beat replaces the drained one, and down_valid stays 1.
- Output rules:
  - At most one channel loads per cycle.
  - Any number of channels may drain in the same cycle.
  - down_data[i] and down_valid[i] stay stable while down_valid[i] && !down_ready[i].
- Counters: cnt[i] increments by 1 on each channel-i output handshake (down_valid[i] && down_ready[i]).
  - Wraps 255 -> 0.
  - cnt_clear sets all counters to 0 and has priority over a same-cycle increment, so the result is 0 and that beat is not counted.
- up_data and up_sel are don't-care when up_valid is 0.
- No FSM beyond the four per-channel valid bits. Each channel is either EMPTY or FULL:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain with load, or on stall.

## Timing
- Reset (rst_n low, asynchronous): down_valid = 0, down_data = 0, cnt = 0, and up_ready is forced to 0 while rst_n is low.
- After release: up_ready may go high in the first cycle with rst_n high.
- Reset mid-operation discards all held beats immediately, with no output handshake and no count.
- Latency: an accepted beat appears on down_valid[i] and down_data[i] in the cycle after the transfer edge.
- Throughput: one beat per cycle to a single channel while its down_ready is held 1.
  - Alternating channels also sustain one beat per cycle.
- cnt reflects a handshake in the cycle after it occurs.
- cnt_clear acts in the cycle after it is sampled.

## Test plan
- Reset: hold rst_n=0 with up_valid=1 -> up_ready=0, down_valid=4'b0000, down_data=16'h0000, cnt=32'h0. Release -> up_ready=1.
- Routing: send data 4'hA/sel 0, 4'h5/sel 1, 4'hC/sel 2, 4'h3/sel 3 on consecutive cycles with down_ready=0. Expected:
  - down_valid=4'b1111 and down_data=16'h3C5A.
  - A fifth beat to sel 2 sees up_ready=0.
  - A beat to any channel is blocked until its ready is raised.
- Stall/replace on channel 1: channel 1 holds 4'h7 with down_ready[1]=0 -> data stable for 5 cycles. Then set down_ready[1]=1 with input 4'h9/sel 1 in the same cycle -> next cycle down_valid[1]=1, data 4'h9, cnt[1]=1.
- Streaming: 300 back-to-back beats to channel 3 with down_ready=4'b1000 -> up_ready stays 1 throughout, each beat emerges one cycle later in order, and cnt[3] ends at 300 mod 256 = 44.
- Counter clear collision: assert cnt_clear in the same cycle as a channel-0 handshake -> cnt[7:0]=0 next cycle. The next handshake gives 1.
- Async reset mid-stream: drop rst_n between clock edges while channels 0 and 2 are full -> down_valid clears immediately without waiting for an edge, and cnt=0.
